suav_vote_n: RTL and testbench

Parametrised multi-channel sliding-window vote filter; the next-generation input smoother for the alarm control system. Each of CH binary inputs (sensor/switch lines) is sampled into a WIN-deep window. A hysteresis decision on the count of ones in that window drives a clean output per channel, plus one-cycle rise/fall event pulses for the alarm state logic. It sits between the input synchronisers and the alarm controller.

---
 rtl/suav_pkg.sv | 29 ++
 rtl/suav_chan.sv | 73 +++++++
 rtl/suav_vote_n.sv | 67 ++++++
 tb/tb_suav_vote_n.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/suav_pkg.sv
// Shared constants and helpers for the suav_vote_n sliding-window vote filter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package suav_pkg;

    localparam int DEF_CH     = 4;
    localparam int DEF_WIN    = 8;
    localparam int DEF_TH_ON  = 5;
    localparam int DEF_TH_OFF = 3;

    // Ceiling log2, usable in constant expressions (port widths, localparams).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Legal configuration: window of at least two samples and
    // 0 <= TH_OFF < TH_ON <= WIN so the hysteresis band is non-empty.
    function automatic bit params_ok(input int ch, input int win, input int th_on, input int th_off);
        return (ch >= 1) && (win >= 2) && (th_off >= 0) && (th_off < th_on) && (th_on <= win);
    endfunction

endpackage

// File: rtl/suav_chan.sv
// One filter channel: WIN-deep sample window, exact ones count, hysteresis output, edge pulses.
// Latency: a sample taken on an edge is reflected in count/out/rise/fall right after that edge.
// Backpressure: none; i_en is a sample strobe and everything holds while it is low (pulses still clear).
module suav_chan
    import suav_pkg::*;
#(
    parameter int WIN    = DEF_WIN,
    parameter int TH_ON  = DEF_TH_ON,
    parameter int TH_OFF = DEF_TH_OFF
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic                       i_in,
    output logic                       o_out,
    output logic                       o_rise,
    output logic                       o_fall,
    output logic [clog2(WIN+1)-1:0]    o_cnt
);

    localparam int CW = clog2(WIN + 1);
    localparam logic [CW-1:0] TH_ON_C  = CW'(TH_ON);
    localparam logic [CW-1:0] TH_OFF_C = CW'(TH_OFF);

    // Bit 0 is the newest sample, bit WIN-1 the oldest.
    logic [WIN-1:0] r_win;
    logic [CW-1:0]  r_cnt;
    logic           r_out;
    logic           r_rise;
    logic           r_fall;

    logic [CW-1:0]  w_cnt_nxt;
    logic           w_set;
    logic           w_clr;

    // Next count and hysteresis decision; the count is exact so modular arithmetic never wraps.
    always_comb begin
        w_cnt_nxt = r_cnt + CW'(i_in) - CW'(r_win[WIN-1]);
        w_set     = !r_out && (w_cnt_nxt >= TH_ON_C);
        w_clr     =  r_out && (w_cnt_nxt <= TH_OFF_C);
    end

    // Window, count and output state; reset forces out low without a fall pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_win  <= '0;
            r_cnt  <= '0;
            r_out  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (i_en) begin
                r_win <= {r_win[WIN-2:0], i_in};
                r_cnt <= w_cnt_nxt;
                if (w_set) begin
                    r_out  <= 1'b1;
                    r_rise <= 1'b1;
                end else if (w_clr) begin
                    r_out  <= 1'b0;
                    r_fall <= 1'b1;
                end
            end
        end
    end

    assign o_out  = r_out;
    assign o_rise = r_rise;
    assign o_fall = r_fall;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/suav_vote_n.sv
// Multi-channel sliding-window vote filter with hysteresis and rise/fall pulses, plus a primed flag.
// Latency: outputs registered; a sample on edge k is visible immediately after edge k.
// Backpressure: none; i_en gates sampling, all state holds while it is low.
module suav_vote_n
    import suav_pkg::*;
#(
    parameter int CH     = DEF_CH,
    parameter int WIN    = DEF_WIN,
    parameter int TH_ON  = DEF_TH_ON,
    parameter int TH_OFF = DEF_TH_OFF
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic [CH-1:0]                 i_in,
    output logic [CH-1:0]                 o_out,
    output logic [CH-1:0]                 o_rise,
    output logic [CH-1:0]                 o_fall,
    output logic [CH*clog2(WIN+1)-1:0]    o_cnt,
    output logic                          o_primed
);

    localparam int CW = clog2(WIN + 1);
    localparam logic [CW-1:0] WIN_C = CW'(WIN);

    if (!params_ok(CH, WIN, TH_ON, TH_OFF)) begin : g_bad_params
        $error("suav_vote_n: illegal CH/WIN/TH_ON/TH_OFF combination");
    end

    logic [CW-1:0] r_scnt;
    logic          r_primed;

    // Shared sample counter saturating at WIN; primed latches when the window first fills.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scnt   <= '0;
            r_primed <= 1'b0;
        end else if (i_en && (r_scnt != WIN_C)) begin
            r_scnt   <= r_scnt + CW'(1);
            r_primed <= (r_scnt == (WIN_C - CW'(1)));
        end
    end

    assign o_primed = r_primed;

    for (genvar i = 0; i < CH; i++) begin : g_chan
        logic [CW-1:0] w_cnt;

        suav_chan #(
            .WIN    (WIN),
            .TH_ON  (TH_ON),
            .TH_OFF (TH_OFF)
        ) u_chan (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_en   (i_en),
            .i_in   (i_in[i]),
            .o_out  (o_out[i]),
            .o_rise (o_rise[i]),
            .o_fall (o_fall[i]),
            .o_cnt  (w_cnt)
        );

        assign o_cnt[i*CW +: CW] = w_cnt;
    end

endmodule

// File: tb/tb_suav_vote_n.sv
// Bench for suav_vote_n: default instance plus a legacy-majority instance (TH_OFF=4).
// Latency: expectations are queued per edge and checked 1 time unit after that edge.
// Backpressure: n/a.
module tb_suav_vote_n;
    import suav_pkg::*;

    localparam int CH  = 4;
    localparam int WIN = 8;
    localparam int TH_ON = 5;
    localparam int CW  = clog2(WIN + 1);
    localparam int TH_OFF_M [2] = '{3, 4};

    logic            clk;
    logic            rst;
    logic            en;
    logic [CH-1:0]   din;

    logic [CH-1:0]    out_a, rise_a, fall_a, out_b, rise_b, fall_b;
    logic [CH*CW-1:0] cnt_a, cnt_b;
    logic             primed_a, primed_b;

    suav_vote_n #(.CH(CH), .WIN(WIN), .TH_ON(TH_ON), .TH_OFF(3)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_in(din),
        .o_out(out_a), .o_rise(rise_a), .o_fall(fall_a), .o_cnt(cnt_a), .o_primed(primed_a)
    );

    suav_vote_n #(.CH(CH), .WIN(WIN), .TH_ON(TH_ON), .TH_OFF(4)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_in(din),
        .o_out(out_b), .o_rise(rise_b), .o_fall(fall_b), .o_cnt(cnt_b), .o_primed(primed_b)
    );

    typedef struct {
        logic [CH-1:0]    out;
        logic [CH-1:0]    rise;
        logic [CH-1:0]    fall;
        logic [CH*CW-1:0] cnt;
        logic             primed;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Reference model: explicit sample history per channel, count as a plain sum.
    int m_hist [2][CH][WIN];
    bit m_out  [2][CH];
    int m_scnt;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply inputs for the next edge, queue the model's prediction, wait until after the edge.
    task automatic drive(input bit r, input bit e, input logic [CH-1:0] d);
        exp_t x;
        rst = r;
        en  = e;
        din = d;
        if (r) m_scnt = 0;
        else if (e && m_scnt < WIN) m_scnt++;
        for (int k = 0; k < 2; k++) begin
            x.rise = '0;
            x.fall = '0;
            x.cnt  = '0;
            x.out  = '0;
            for (int c = 0; c < CH; c++) begin
                int s;
                s = 0;
                if (r) begin
                    for (int w = 0; w < WIN; w++) m_hist[k][c][w] = 0;
                    m_out[k][c] = 1'b0;
                end else if (e) begin
                    for (int w = WIN - 1; w > 0; w--) m_hist[k][c][w] = m_hist[k][c][w-1];
                    m_hist[k][c][0] = int'(d[c]);
                    for (int w = 0; w < WIN; w++) s += m_hist[k][c][w];
                    if (!m_out[k][c] && s >= TH_ON) begin
                        m_out[k][c] = 1'b1;
                        x.rise[c] = 1'b1;
                    end else if (m_out[k][c] && s <= TH_OFF_M[k]) begin
                        m_out[k][c] = 1'b0;
                        x.fall[c] = 1'b1;
                    end
                end
                s = 0;
                for (int w = 0; w < WIN; w++) s += m_hist[k][c][w];
                x.cnt[c*CW +: CW] = CW'(s);
                x.out[c] = m_out[k][c];
            end
            x.primed = (m_scnt == WIN);
            if (k == 0) qa.push_back(x);
            else        qb.push_back(x);
        end
        @(negedge clk);
    endtask

    // Monitor: every edge is an output event; pop and compare each instance.
    initial begin
        exp_t ea;
        exp_t eb;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                chk("a_out",    64'(out_a),    64'(ea.out));
                chk("a_rise",   64'(rise_a),   64'(ea.rise));
                chk("a_fall",   64'(fall_a),   64'(ea.fall));
                chk("a_cnt",    64'(cnt_a),    64'(ea.cnt));
                chk("a_primed", 64'(primed_a), 64'(ea.primed));
            end
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                chk("b_out",    64'(out_b),    64'(eb.out));
                chk("b_rise",   64'(rise_b),   64'(eb.rise));
                chk("b_fall",   64'(fall_b),   64'(eb.fall));
                chk("b_cnt",    64'(cnt_b),    64'(eb.cnt));
                chk("b_primed", 64'(primed_b), 64'(eb.primed));
            end
        end
    end

    initial begin
        logic [CH-1:0] d;
        bit            ph;
        m_scnt = 0;

        // Reset held two cycles with all inputs high.
        drive(1'b1, 1'b1, 4'hF);
        drive(1'b1, 1'b1, 4'hF);
        chk("rst_out",    64'(out_a),    64'd0);
        chk("rst_pulses", 64'(rise_a | fall_a), 64'd0);
        chk("rst_cnt",    64'(cnt_a),    64'd0);
        chk("rst_primed", 64'(primed_a), 64'd0);

        // Fill: ch0 constant one, ch1 alternating starting with one.
        ph = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            d = {2'b00, ph, 1'b1};
            ph = ~ph;
            drive(1'b0, 1'b1, d);
            chk("fill_cnt0", 64'(cnt_a[CW-1:0]), 64'(k));
            if (k == 4) chk("fill_out0_k4",  64'(out_a[0]),  64'd0);
            if (k == 5) chk("fill_rise0_k5", 64'(rise_a[0]), 64'd1);
            if (k == 5) chk("fill_out0_k5",  64'(out_a[0]),  64'd1);
            if (k == 6) chk("fill_rise0_k6", 64'(rise_a[0]), 64'd0);
            if (k == 7) chk("fill_primed_k7", 64'(primed_a), 64'd0);
        end
        chk("fill_primed_k8", 64'(primed_a), 64'd1);

        // Steady state: ch0 saturated, ch1 alternating keeps count at 4.
        for (int k = 0; k < 20; k++) begin
            d = {2'b00, ph, 1'b1};
            ph = ~ph;
            drive(1'b0, 1'b1, d);
            chk("steady_cnt1", 64'(cnt_a[2*CW-1:CW]), 64'd4);
            chk("steady_cnt0", 64'(cnt_a[CW-1:0]), 64'd8);
            chk("steady_pulses", 64'(rise_a[1] | fall_a[1]), 64'd0);
        end

        // Hysteresis on ch0: ones drain out of the window.
        for (int k = 1; k <= 6; k++) begin
            d = {2'b00, ph, 1'b0};
            ph = ~ph;
            drive(1'b0, 1'b1, d);
            if (k <= 4) chk("hyst_out0_held", 64'(out_a[0]), 64'd1);
            if (k == 4) chk("hyst_cnt0_k4",   64'(cnt_a[CW-1:0]), 64'd4);
            if (k == 5) chk("hyst_cnt0_k5",   64'(cnt_a[CW-1:0]), 64'd3);
            if (k == 5) chk("hyst_out0_k5",   64'(out_a[0]), 64'd0);
            if (k == 5) chk("hyst_fall0_k5",  64'(fall_a[0]), 64'd1);
            if (k == 6) chk("hyst_fall0_k6",  64'(fall_a[0]), 64'd0);
        end

        // Refill ch0 so out0 is high before the gating test.
        for (int k = 0; k < 8; k++) drive(1'b0, 1'b1, 4'h1);

        // en low with toggling inputs: nothing moves.
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b0, (k % 2 == 0) ? 4'hA : 4'h5);
            chk("gate_out0",  64'(out_a[0]), 64'd1);
            chk("gate_cnt0",  64'(cnt_a[CW-1:0]), 64'd8);
            chk("gate_pulse", 64'(rise_a | fall_a), 64'd0);
        end

        // Single-cycle reset mid-operation.
        drive(1'b1, 1'b1, 4'hF);
        chk("mrst_out",    64'(out_a),    64'd0);
        chk("mrst_fall",   64'(fall_a),   64'd0);
        chk("mrst_cnt",    64'(cnt_a),    64'd0);
        chk("mrst_primed", 64'(primed_a), 64'd0);

        // Random samples, en always high (legacy instance compared every cycle).
        for (int k = 0; k < 500; k++) drive(1'b0, 1'b1, CH'($urandom));

        // Random samples with random en and occasional reset.
        for (int k = 0; k < 300; k++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), CH'($urandom));
        end

        drive(1'b0, 1'b0, '0);
        chk("queues_drained", 64'(qa.size() + qb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
